fpu_add_pipe: RTL and testbench

Pipelined, parametrised IEEE-754 floating-point adder/subtractor for the FPU datapath. It accepts two packed operands and an add/sub select, and handles special cases internally. Alignment, signed magnitude add, leading-zero normalisation and round-to-nearest-even run in three registered stages behind a valid/ready handshake. The block sits between the operand-read stage and the FPU writeback arbiter and returns a packed IEEE result plus exception flags.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fpu_lzc.sv | 16 +
 rtl/fpu_add_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_fpu_add_pipe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types, widths and helpers.
// Used by the adder pipeline and other FPU datapath units.
package fpu_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;

   localparam int FLAG_NV = 2;
   localparam int FLAG_OF = 1;
   localparam int FLAG_NX = 0;

   typedef struct packed {
      logic                 sign;
      logic [EXP_W_DEF:0]   exp;
      logic [MAN_W_DEF:0]   mant;
      logic [2:0]           grs;
   } fp_stage_t;

   // Canonical quiet NaN {0, all-ones exp, 1 then zeros}
   function automatic logic [63:0] qnan(input int ew, input int mw);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < ew; i++) r[mw+i] = 1'b1;
      r[mw-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input returns WIDTH.
module fpu_lzc #(
   parameter int  WIDTH = 24,
   localparam int CW    = $clog2(WIDTH+1)
) (
   input  logic [WIDTH-1:0] data_i,
   output logic [CW-1:0]    cnt_o
);

   always_comb begin
      cnt_o = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++)
         if (data_i[i]) cnt_o = CW'(WIDTH-1-i);
   end

endmodule

// File: rtl/fpu_add_pipe.sv
// Pipelined IEEE-754 adder/subtractor, RNE only.
// Input capture, then align, add and normalise/round stages.
module fpu_add_pipe
   import fpu_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [EXP_W+MAN_W:0]   a_i,
   input  logic [EXP_W+MAN_W:0]   b_i,
   input  logic                   sub_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [EXP_W+MAN_W:0]   sum_o,
   output logic [2:0]             flags_o
);

   localparam int W  = EXP_W+MAN_W+1;
   localparam int MW = MAN_W+4;
   localparam int SW = MAN_W+5;
   localparam int E1 = EXP_W+1;
   localparam int LW = $clog2(MW+1);

   typedef struct packed {
      logic          sign;
      logic [E1-1:0] exp;
      logic [MW-1:0] big;
      logic [MW-1:0] sml;
      logic          sub;
      logic          spec;
      logic [W-1:0]  sres;
      logic          snv;
   } s1_t;

   typedef struct packed {
      logic          sign;
      logic [E1-1:0] exp;
      logic [SW-1:0] sum;
      logic          sub;
      logic          spec;
      logic [W-1:0]  sres;
      logic          snv;
   } s2_t;

   logic          adv;
   logic          v0_q, v1_q, v2_q, v3_q;
   logic [W-1:0]  a_q, b_q;
   logic          sub_q;
   s1_t           s1_d, s1_q;
   s2_t           s2_d, s2_q;
   logic [W-1:0]  sum_d, sum_q;
   logic [2:0]    flags_d, flags_q;

   assign adv     = ~v3_q | ready_i;
   assign ready_o = adv;
   assign valid_o = v3_q;
   assign sum_o   = sum_q;
   assign flags_o = flags_q;

   // Stage 1: decode, specials, swap and align
   logic              sa, sb, a_nan, b_nan, a_inf, b_inf, a_big, lost;
   logic [EXP_W-1:0]  ea_f, eb_f;
   logic [MAN_W-1:0]  fa, fb;
   logic [E1-1:0]     ea, eb, big_e, sml_e, diff, sh1;
   logic [MAN_W:0]    ma, mb, big_m, sml_m;
   logic [MW-1:0]     ext, shd;

   assign {sa, ea_f, fa} = a_q;
   assign eb_f  = b_q[W-2:MAN_W];
   assign fb    = b_q[MAN_W-1:0];
   assign sb    = b_q[W-1] ^ sub_q;
   assign ea    = (ea_f == '0) ? E1'(1) : E1'(ea_f);
   assign eb    = (eb_f == '0) ? E1'(1) : E1'(eb_f);
   assign ma    = {|ea_f, fa};
   assign mb    = {|eb_f, fb};
   assign a_nan = &ea_f & |fa;
   assign b_nan = &eb_f & |fb;
   assign a_inf = &ea_f & ~|fa;
   assign b_inf = &eb_f & ~|fb;
   assign a_big = {ea, ma} >= {eb, mb};
   assign big_e = a_big ? ea : eb;
   assign sml_e = a_big ? eb : ea;
   assign big_m = a_big ? ma : mb;
   assign sml_m = a_big ? mb : ma;
   assign diff  = big_e - sml_e;
   assign sh1   = (diff > E1'(MW-1)) ? E1'(MW-1) : diff;
   assign ext   = {sml_m, 3'b000};
   assign shd   = ext >> sh1;
   assign lost  = |(ext & ~({MW{1'b1}} << sh1));

   always_comb begin
      s1_d      = '0;
      s1_d.sign = a_big ? sa : sb;
      s1_d.exp  = big_e;
      s1_d.big  = {big_m, 3'b000};
      s1_d.sml  = {shd[MW-1:1], shd[0] | lost};
      s1_d.sub  = sa ^ sb;
      if (a_nan | b_nan | (a_inf & b_inf & (sa != sb))) begin
         s1_d.spec = 1'b1;
         s1_d.sres = W'(qnan(EXP_W, MAN_W));
         s1_d.snv  = (a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1])
                   | (a_inf & b_inf);
      end else if (a_inf) begin
         s1_d.spec = 1'b1;
         s1_d.sres = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         s1_d.spec = 1'b1;
         s1_d.sres = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   // Stage 2: signed-magnitude add; big >= small so never negative
   always_comb begin
      s2_d      = '0;
      s2_d.sign = s1_q.sign;
      s2_d.exp  = s1_q.exp;
      s2_d.sub  = s1_q.sub;
      s2_d.spec = s1_q.spec;
      s2_d.sres = s1_q.sres;
      s2_d.snv  = s1_q.snv;
      s2_d.sum  = s1_q.sub ? {1'b0, s1_q.big} - {1'b0, s1_q.sml}
                           : {1'b0, s1_q.big} + {1'b0, s1_q.sml};
   end

   // Stage 3: normalise, round to nearest even, pack
   logic [LW-1:0]   lz;
   logic [E1-1:0]   lim, sh3, e_n, e_r;
   logic [MW-1:0]   m;
   logic [MAN_W+1:0] mr;
   logic [MAN_W:0]  mf;
   logic            nx, rup;

   fpu_lzc #(.WIDTH(MW)) u_lzc (
      .data_i (s2_q.sum[MW-1:0]),
      .cnt_o  (lz)
   );

   always_comb begin
      lim     = s2_q.exp - E1'(1);
      sh3     = (E1'(lz) > lim) ? lim : E1'(lz);
      m       = s2_q.sum[MW-1:0] << sh3;
      e_n     = s2_q.exp - sh3;
      if (s2_q.sum[SW-1]) begin
         m   = {s2_q.sum[SW-1:2], s2_q.sum[1] | s2_q.sum[0]};
         e_n = s2_q.exp + E1'(1);
      end
      nx      = |m[2:0];
      rup     = m[2] & (m[1] | m[0] | m[3]);
      mr      = {1'b0, m[MW-1:3]} + (MAN_W+2)'(rup);
      mf      = mr[MAN_W:0];
      e_r     = e_n;
      if (mr[MAN_W+1]) begin
         mf  = mr[MAN_W+1:1];
         e_r = e_n + E1'(1);
      end
      flags_d = '0;
      if (s2_q.spec) begin
         sum_d            = s2_q.sres;
         flags_d[FLAG_NV] = s2_q.snv;
      end else if (e_r >= E1'((1 << EXP_W) - 1)) begin
         sum_d            = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d[FLAG_OF] = 1'b1;
         flags_d[FLAG_NX] = 1'b1;
      end else begin
         sum_d = {s2_q.sign & ~(s2_q.sub & ~|mf),
                  mf[MAN_W] ? e_r[EXP_W-1:0] : {EXP_W{1'b0}},
                  mf[MAN_W-1:0]};
         flags_d[FLAG_NX] = nx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         s1_q    <= '0;
         s2_q    <= '0;
         sum_q   <= '0;
         flags_q <= '0;
      end else if (adv) begin
         v0_q <= valid_i;
         v1_q <= v0_q;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            sub_q <= sub_i;
         end
         if (v0_q) s1_q <= s1_d;
         if (v1_q) s2_q <= s2_d;
         if (v2_q) begin
            sum_q   <= sum_d;
            flags_q <= flags_d;
         end
      end
   end

endmodule

// File: tb/tb_fpu_add_pipe.sv
// Directed-vector bench for fpu_add_pipe (single precision).
// Table loop plus back-pressure and mid-stream reset sequences.
module tb_fpu_add_pipe;

   localparam int NV = 18;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b1;
   logic        sub_i = 1'b0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        ready_o, valid_o;
   logic [31:0] sum_o;
   logic [2:0]  flags_o;

   int n_pass = 0;
   int n_tot  = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] s;
      logic [2:0]  f;
   } vec_t;

   vec_t vt[NV];

   fpu_add_pipe dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .a_i     (a_i),
      .b_i     (b_i),
      .sub_i   (sub_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .sum_o   (sum_o),
      .flags_o (flags_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic run_vec(input int i);
      int lat;
      @(negedge clk_i);
      a_i     = vt[i].a;
      b_i     = vt[i].b;
      sub_i   = vt[i].sub;
      valid_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
      lat     = 0;
      while (!valid_o && lat < 20) begin
         @(negedge clk_i);
         lat++;
      end
      chk($sformatf("lat%0d", i), lat, 3);
      chk($sformatf("sum%0d", i), sum_o, vt[i].s);
      chk($sformatf("flg%0d", i), 32'(flags_o), 32'(vt[i].f));
   endtask

   initial begin
      int ord[6];
      int prod, cons, cyc, extra;
      logic pstall;
      logic [31:0] psum;
      logic [2:0]  pfl;

      vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
      vt[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
      vt[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
      vt[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100};
      vt[4]  = '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
      vt[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011};
      vt[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001};
      vt[7]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000};
      vt[8]  = '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000};
      vt[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000};
      vt[10] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
      vt[11] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001};
      vt[12] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000};
      vt[13] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000};
      vt[14] = '{32'h40000000, 32'h3FFFFFFF, 1'b1, 32'h34000000, 3'b000};
      vt[15] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000};
      vt[16] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000};
      vt[17] = '{32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 3'b000};

      repeat (3) @(negedge clk_i);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_sum", sum_o, 32'd0);
      chk("rst_flags", 32'(flags_o), 32'd0);
      rst_ni = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(i);

      // Back-pressure: 6 ops streamed, ready_i low for cycles 5..9
      ord    = '{0, 13, 14, 6, 7, 5};
      prod   = 0;
      cons   = 0;
      cyc    = 0;
      pstall = 1'b0;
      psum   = '0;
      pfl    = '0;
      while (cons < 6 && cyc < 60) begin
         @(negedge clk_i);
         ready_i = !(cyc >= 5 && cyc < 10);
         if (prod < 6) begin
            valid_i = 1'b1;
            a_i     = vt[ord[prod]].a;
            b_i     = vt[ord[prod]].b;
            sub_i   = vt[ord[prod]].sub;
         end else begin
            valid_i = 1'b0;
         end
         #1;
         if (pstall) begin
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_sum", sum_o, psum);
            chk("hold_flags", 32'(flags_o), 32'(pfl));
         end
         if (!ready_i) chk("stall_ready", 32'(ready_o), 32'd0);
         else chk("run_ready", 32'(ready_o), 32'd1);
         if (valid_o && ready_i) begin
            chk($sformatf("bp_sum%0d", cons), sum_o, vt[ord[cons]].s);
            chk($sformatf("bp_flg%0d", cons), 32'(flags_o),
                32'(vt[ord[cons]].f));
            cons++;
         end
         if (valid_i && ready_o) prod++;
         pstall = valid_o && !ready_i;
         psum   = sum_o;
         pfl    = flags_o;
         cyc++;
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      chk("bp_count", cons, 6);
      extra = 0;
      repeat (6) begin
         @(negedge clk_i);
         if (valid_o) extra++;
      end
      chk("bp_dup", extra, 0);

      // Reset while results are in flight
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         valid_i = 1'b1;
         a_i     = vt[k].a;
         b_i     = vt[k].b;
         sub_i   = vt[k].sub;
      end
      @(negedge clk_i);
      valid_i = 1'b0;
      ready_i = 1'b0;
      #1;
      chk("pre_rst_valid", 32'(valid_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(valid_o), 32'd0);
      chk("mid_rst_ready", 32'(ready_o), 32'd1);
      chk("mid_rst_sum", sum_o, 32'd0);
      @(negedge clk_i);
      rst_ni  = 1'b1;
      ready_i = 1'b1;
      extra   = 0;
      repeat (8) begin
         @(negedge clk_i);
         if (valid_o) extra++;
      end
      chk("post_rst_ghost", extra, 0);
      run_vec(10);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
